asic_dma_master: RTL and testbench
==================================

// Module: asic_dma_master
// PURPOSE
//  AXI4 initiator (single-beat, LEN=0) copy engine that feeds and drains the ASIC MMIO slave.
//  - Accepts one copy command: N words from a source address to a destination address,
//    with each address independently incrementing or fixed.
//  - Each word is one AR/R read followed by one AW/W/B write.
//  - Fixed-address mode streams 1104 ifmap/weight/bias words from memory into ASIC DATA (0x04),
//    or drains ofmap words from ASIC OFMAP (0x08) into memory.
//  - Sits between the CPU command regs and the AXI interconnect master port.
// PARAMETERS
//  ADDR_W  32    AXI address width
//  DATA_W  32    AXI data width; word stride is DATA_W/8 = 4 bytes
//  LEN_W   11    command word-count width (max 2047; covers 1104)
//  TXN_ID  4'h0  constant ID driven on AWID_M/ARID_M
// PORTS
//  ACLK              in   1       clock
//  ARESETn           in   1       asynchronous active-low reset
//  cmd_valid         in   1       command request
//  cmd_ready         out  1       high in IDLE only
//  cmd_src           in   ADDR_W  first source byte address (word aligned)
//  cmd_dst           in   ADDR_W  first destination byte address (word aligned)
//  cmd_len           in   LEN_W   word count; 0 = no-op
//  cmd_src_inc       in   1       1: src += 4 per word; 0: fixed
//  cmd_dst_inc       in   1       1: dst += 4 per word; 0: fixed
//  done              out  1       one-cycle pulse at end of command
//  err               out  1       valid with done; 1 = a non-OKAY response aborted the copy
//  busy              out  1       state != IDLE
//  words_done        out  LEN_W   words fully written (B=OKAY) for the current/last command
//  ARID_M/AWID_M     out  4       TXN_ID
//  ARADDR_M/AWADDR_M out  ADDR_W  current src / dst address
//  ARLEN_M/AWLEN_M   out  4       0
//  ARSIZE_M/AWSIZE_M out  3       3'b010 (word)
//  ARBURST_M/AWBURST_M out 2      2'h1 (INCR)
//  ARVALID_M/ARREADY_M out/in 1   read address handshake
//  RID_M, RDATA_M, RRESP_M, RLAST_M  in  4/DATA_W/2/1  read data beat
//  RVALID_M/RREADY_M in/out 1     read data handshake
//  WDATA_M           out  DATA_W  registered read data
//  WSTRB_M           out  4       4'b1111
//  WLAST_M           out  1       1 whenever WVALID_M is high
//  WVALID_M/WREADY_M out/in 1     write data handshake
//  AWVALID_M/AWREADY_M out/in 1   write address handshake
//  BID_M, BRESP_M    in   4/2     write response
//  BVALID_M/BREADY_M in/out 1     write response handshake
// BEHAVIOUR
//  Reset (async, ARESETn=0): state=IDLE; every VALID/READY output, done, err, words_done,
//  and data register = 0. Reset mid-transaction drops the transaction; there is no replay.
//  FSM: IDLE -> RD_ADDR -> RD_DATA -> WR -> WR_RESP -> (RD_ADDR | FIN) ; FIN -> IDLE.
//   IDLE:    on cmd_valid, latch src/dst/len/inc flags, clear words_done and err.
//            len=0 -> FIN; otherwise -> RD_ADDR.
//   RD_ADDR: ARVALID_M=1 until ARREADY_M, then -> RD_DATA.
//   RD_DATA: RREADY_M=1. On RVALID_M, latch RDATA_M. RLAST_M and RID_M are ignored.
//            RRESP_M!=OKAY -> err=1, FIN; otherwise -> WR.
//   WR:      AWVALID_M and WVALID_M both assert on entry. Each drops independently after
//            its own handshake, tracked by aw_done/w_done flags (both READYs in one cycle
//            is allowed). When both flags are set -> WR_RESP.
//   WR_RESP: BREADY_M=1. On BVALID_M: BRESP_M!=OKAY -> err=1, FIN. Otherwise words_done++,
//            src/dst advance by 4 if their inc flag is set, and remaining--.
//            If remaining reaches 0 -> FIN; otherwise -> RD_ADDR.
//   FIN:     done=1 for exactly one cycle, then -> IDLE.
//  Handshake rules:
//   - VALID outputs are registered and never depend combinationally on READY.
//   - Address/data stay stable while VALID is high and READY is low.
//  Arithmetic: address increments wrap modulo 2^ADDR_W; remaining counter is LEN_W bits.
//  Latency: zero-wait slave = 4 cycles/word; command accept -> done = 4*N + 1 cycles.
//  cmd_valid outside IDLE is ignored, because cmd_ready=0.
// STRUCTURE
//  Package asic_axi_pkg:
//   - AXI constants: LEN_ONE, SIZE_WORD, BURST_INC, STRB_WORD, RESP_OKAY/SLVERR/DECERR
//   - MMIO offsets ENABLE/DATA/OFMAP
//   - dma_state_t enum
//  Single module; no sub-module is natural.
// TESTING
//  1. len=3, src=0x1000 inc, dst=0x04 fixed, memory {A,B,C}, zero-wait slave
//     -> W beats A,B,C all at AWADDR 0x04; done at cycle 13; words_done=3; err=0.
//  2. AWREADY_M delayed 3 cycles, WREADY_M immediate -> exactly one W beat;
//     AWADDR_M stable while waiting; B only after both handshakes.
//  3. len=4, RRESP=SLVERR on word 2 -> no AW/W for word 2; done with err=1; words_done=1.
//  4. len=0 -> done one cycle after accept; no AXI valids; err=0.
//  5. ARESETn low during WR_RESP -> all valids 0 immediately; after release, cmd_ready=1 and busy=0.
//  6. cmd_valid pulsed while busy -> ignored; second command accepted after done,
//     with words_done restarted from 0.

Source files
------------

// File: rtl/asic_axi_pkg.sv
// rtl/asic_axi_pkg.sv - AXI constants, ASIC MMIO offsets and DMA state type
package asic_axi_pkg;

    localparam logic [3:0] LEN_ONE    = 4'h0;
    localparam logic [2:0] SIZE_WORD  = 3'b010;
    localparam logic [1:0] BURST_INC  = 2'h1;
    localparam logic [3:0] STRB_WORD  = 4'b1111;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] MMIO_ENABLE = 32'h0000_0000;
    localparam logic [31:0] MMIO_DATA   = 32'h0000_0004;
    localparam logic [31:0] MMIO_OFMAP  = 32'h0000_0008;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR,
        ST_WR_RESP,
        ST_FIN
    } dma_state_t;

endpackage

// File: rtl/asic_dma_master.sv
// rtl/asic_dma_master.sv - single-beat AXI4 copy engine: one read then one write per word
module asic_dma_master
    import asic_axi_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter int         LEN_W  = 11,
    parameter logic [3:0] TXN_ID = 4'h0
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_src_inc,
    input  logic              cmd_dst_inc,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic [LEN_W-1:0]  words_done,
    output logic [3:0]        ARID_M,
    output logic [ADDR_W-1:0] ARADDR_M,
    output logic [3:0]        ARLEN_M,
    output logic [2:0]        ARSIZE_M,
    output logic [1:0]        ARBURST_M,
    output logic              ARVALID_M,
    input  logic              ARREADY_M,
    input  logic [3:0]        RID_M,
    input  logic [DATA_W-1:0] RDATA_M,
    input  logic [1:0]        RRESP_M,
    input  logic              RLAST_M,
    input  logic              RVALID_M,
    output logic              RREADY_M,
    output logic [3:0]        AWID_M,
    output logic [ADDR_W-1:0] AWADDR_M,
    output logic [3:0]        AWLEN_M,
    output logic [2:0]        AWSIZE_M,
    output logic [1:0]        AWBURST_M,
    output logic              AWVALID_M,
    input  logic              AWREADY_M,
    output logic [DATA_W-1:0] WDATA_M,
    output logic [3:0]        WSTRB_M,
    output logic              WLAST_M,
    output logic              WVALID_M,
    input  logic              WREADY_M,
    input  logic [3:0]        BID_M,
    input  logic [1:0]        BRESP_M,
    input  logic              BVALID_M,
    output logic              BREADY_M
);

    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);

    dma_state_t        state_q, state_d;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  rem_q, words_done_q;
    logic              src_inc_q, dst_inc_q;
    logic              err_q;
    logic [DATA_W-1:0] wdata_q;
    logic              aw_done_q, w_done_q;
    logic              aw_fire, w_fire;

    logic unused_inputs;
    assign unused_inputs = ^{RID_M, RLAST_M, BID_M};

    assign aw_fire = AWVALID_M && AWREADY_M;
    assign w_fire  = WVALID_M && WREADY_M;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) state_d = (cmd_len == '0) ? ST_FIN : ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                if (ARREADY_M) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (RVALID_M) state_d = (RRESP_M != RESP_OKAY) ? ST_FIN : ST_WR;
            end
            ST_WR: begin
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (BVALID_M) begin
                    if (BRESP_M != RESP_OKAY || rem_q == LEN_W'(1)) state_d = ST_FIN;
                    else                                              state_d = ST_RD_ADDR;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            src_q        <= '0;
            dst_q        <= '0;
            rem_q        <= '0;
            src_inc_q    <= 1'b0;
            dst_inc_q    <= 1'b0;
            words_done_q <= '0;
            err_q        <= 1'b0;
            wdata_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        src_q        <= cmd_src;
                        dst_q        <= cmd_dst;
                        rem_q        <= cmd_len;
                        src_inc_q    <= cmd_src_inc;
                        dst_inc_q    <= cmd_dst_inc;
                        words_done_q <= '0;
                        err_q        <= 1'b0;
                    end
                end
                ST_RD_DATA: begin
                    // Flags cleared here so AW/W both present on the first WR cycle
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    if (RVALID_M) begin
                        wdata_q <= RDATA_M;
                        if (RRESP_M != RESP_OKAY) err_q <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (aw_fire) aw_done_q <= 1'b1;
                    if (w_fire)  w_done_q  <= 1'b1;
                end
                ST_WR_RESP: begin
                    if (BVALID_M) begin
                        if (BRESP_M != RESP_OKAY) begin
                            err_q <= 1'b1;
                        end else begin
                            words_done_q <= words_done_q + LEN_W'(1);
                            rem_q        <= rem_q - LEN_W'(1);
                            if (src_inc_q) src_q <= src_q + WORD_BYTES;
                            if (dst_inc_q) dst_q <= dst_q + WORD_BYTES;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decode registered state only, never the incoming READYs
    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FIN);
    assign err        = err_q;
    assign words_done = words_done_q;

    assign ARID_M    = TXN_ID;
    assign ARADDR_M  = src_q;
    assign ARLEN_M   = LEN_ONE;
    assign ARSIZE_M  = SIZE_WORD;
    assign ARBURST_M = BURST_INC;
    assign ARVALID_M = (state_q == ST_RD_ADDR);
    assign RREADY_M  = (state_q == ST_RD_DATA);

    assign AWID_M    = TXN_ID;
    assign AWADDR_M  = dst_q;
    assign AWLEN_M   = LEN_ONE;
    assign AWSIZE_M  = SIZE_WORD;
    assign AWBURST_M = BURST_INC;
    assign AWVALID_M = (state_q == ST_WR) && !aw_done_q;

    assign WDATA_M   = wdata_q;
    assign WSTRB_M   = STRB_WORD;
    assign WVALID_M  = (state_q == ST_WR) && !w_done_q;
    assign WLAST_M   = WVALID_M;

    assign BREADY_M  = (state_q == ST_WR_RESP);

endmodule

// File: tb/tb_asic_dma_master.sv
// tb/tb_asic_dma_master.sv - scoreboard bench for asic_dma_master with a reactive AXI slave
module tb_asic_dma_master;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_src, cmd_dst;
    logic [10:0] cmd_len;
    logic        cmd_src_inc, cmd_dst_inc;
    logic        done, err, busy;
    logic [10:0] words_done;
    logic [3:0]  ARID_M, ARLEN_M, AWID_M, AWLEN_M, WSTRB_M;
    logic [31:0] ARADDR_M, AWADDR_M, WDATA_M;
    logic [2:0]  ARSIZE_M, AWSIZE_M;
    logic [1:0]  ARBURST_M, AWBURST_M;
    logic        ARVALID_M, ARREADY_M, RREADY_M, AWVALID_M, AWREADY_M;
    logic        WLAST_M, WVALID_M, WREADY_M, BREADY_M;
    logic [3:0]  RID_M, BID_M;
    logic [31:0] RDATA_M;
    logic [1:0]  RRESP_M, BRESP_M;
    logic        RLAST_M, RVALID_M, BVALID_M;

    asic_dma_master dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .cmd_len(cmd_len), .cmd_src_inc(cmd_src_inc), .cmd_dst_inc(cmd_dst_inc),
        .done(done), .err(err), .busy(busy), .words_done(words_done),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
        .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
        .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
        .WREADY_M(WREADY_M), .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M),
        .BREADY_M(BREADY_M)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] mem [logic [31:0]];
    int          n_cmp = 0;
    int          n_err = 0;
    int          w_beats = 0;

    int aw_delay = 0;
    int err_word = -1;
    int rd_base  = 0;
    bit b_hold   = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hDEAD_0000 ^ a;
    endfunction

    // Reactive slave: ARREADY/WREADY always high, AWREADY after aw_delay cycles
    int          ar_count;
    int          aw_cnt;
    logic        aw_got, w_got;
    logic        s_rvalid, s_bvalid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;

    assign ARREADY_M = 1'b1;
    assign WREADY_M  = 1'b1;
    assign AWREADY_M = (aw_cnt >= aw_delay);
    assign RVALID_M  = s_rvalid;
    assign RDATA_M   = s_rdata;
    assign RRESP_M   = s_rresp;
    assign RID_M     = 4'h0;
    assign RLAST_M   = 1'b1;
    assign BVALID_M  = s_bvalid;
    assign BRESP_M   = 2'b00;
    assign BID_M     = 4'h0;

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ar_count <= 0; aw_cnt <= 0; aw_got <= 0; w_got <= 0;
            s_rvalid <= 0; s_bvalid <= 0; s_rdata <= 0; s_rresp <= 0;
        end else begin
            if (ARVALID_M && ARREADY_M) begin
                s_rvalid <= 1;
                s_rdata  <= mem_rd(ARADDR_M);
                s_rresp  <= (ar_count - rd_base == err_word) ? 2'b10 : 2'b00;
                ar_count <= ar_count + 1;
            end else if (s_rvalid && RREADY_M) begin
                s_rvalid <= 0;
            end
            if (AWVALID_M && AWREADY_M) aw_cnt <= 0;
            else if (AWVALID_M)         aw_cnt <= aw_cnt + 1;
            if (s_bvalid && BREADY_M) s_bvalid <= 0;
            if ((aw_got || (AWVALID_M && AWREADY_M)) && (w_got || (WVALID_M && WREADY_M))) begin
                aw_got <= 0; w_got <= 0;
                if (!b_hold) s_bvalid <= 1;
            end else begin
                if (AWVALID_M && AWREADY_M) aw_got <= 1;
                if (WVALID_M && WREADY_M)   w_got  <= 1;
            end
        end
    end

    // Write-side monitor: pops the scoreboard when a complete AW+W pair is seen
    logic        mon_aw, mon_w, aw_wait;
    logic [31:0] mon_addr, mon_data, aw_hold;
    beat_t       got, want;

    always @(posedge ACLK) begin
        if (!ARESETn) begin
            mon_aw = 0; mon_w = 0; aw_wait = 0;
        end else begin
            if (aw_wait && AWVALID_M) begin
                n_cmp++;
                if (AWADDR_M !== aw_hold) begin
                    n_err++; $display("FAIL awaddr_stable got=%h want=%h", AWADDR_M, aw_hold);
                end
            end
            aw_wait = AWVALID_M && !AWREADY_M;
            aw_hold = AWADDR_M;
            if (BREADY_M) begin
                n_cmp++;
                if ({AWVALID_M, WVALID_M} !== 2'b00) begin
                    n_err++; $display("FAIL bready_before_aw_w got=%b want=00", {AWVALID_M, WVALID_M});
                end
            end
            if (AWVALID_M && AWREADY_M) begin mon_aw = 1; mon_addr = AWADDR_M; end
            if (WVALID_M && WREADY_M) begin
                mon_w = 1; mon_data = WDATA_M; w_beats++;
                n_cmp++;
                if (WLAST_M !== 1'b1 || WSTRB_M !== 4'hF) begin
                    n_err++; $display("FAIL wlast_wstrb got=%b/%h want=1/f", WLAST_M, WSTRB_M);
                end
            end
            if (mon_aw && mon_w) begin
                mon_aw = 0; mon_w = 0;
                got = {mon_addr, mon_data};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL sb_extra_beat got=%h want=none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_err++; $display("FAIL sb_beat got=%h want=%h", got, want);
                    end
                end
            end
        end
    end

    task automatic push_expected(input logic [31:0] s, input logic [31:0] d, input int len,
                                 input bit si, input bit di, input int errw);
        for (int i = 0; i < len; i++) begin
            if (i == errw) break;
            exp_q.push_back({d + (di ? 32'(4 * i) : 32'd0), mem_rd(s + (si ? 32'(4 * i) : 32'd0))});
        end
    endtask

    task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input logic [10:0] len,
                           input bit si, input bit di, input int pulse_at,
                           output int cyc, output logic [10:0] wd_first);
        @(negedge ACLK);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL cmd_ready_idle got=%b want=1", cmd_ready); end
        rd_base = ar_count;
        cmd_src = s; cmd_dst = d; cmd_len = len; cmd_src_inc = si; cmd_dst_inc = di; cmd_valid = 1;
        @(posedge ACLK);
        #1 cmd_valid = 0;
        cyc = 0; wd_first = 'x;
        while (cyc < 5000) begin
            @(negedge ACLK);
            cyc++;
            if (cyc == 1) wd_first = words_done;
            if (pulse_at != 0 && cyc == pulse_at) begin
                n_cmp++;
                if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL cmd_ready_busy got=%b want=0", cmd_ready); end
                cmd_src = 32'h9000; cmd_dst = 32'hA000; cmd_len = 11'd5; cmd_valid = 1;
            end else begin
                cmd_valid = 0;
            end
            if (done) break;
        end
        cmd_valid = 0;
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL done_timeout got=%b want=1", done); end
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL %s_sb_left got=%0d want=0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        ARESETn = 0;
        #1;
        n_cmp++;
        if ({ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M, done, err, busy} !== 8'h00 ||
            words_done !== 11'd0 || WDATA_M !== 32'd0 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state got=%b wd=%0d wdata=%h rdy=%b want=0/0/0/1",
                     {ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M, done, err, busy},
                     words_done, WDATA_M, cmd_ready);
        end
        @(negedge ACLK);
        ARESETn = 1;
    endtask

    task automatic test_copy;
        int cyc; logic [10:0] wd0;
        mem[32'h1000] = 32'hAAAA_0001; mem[32'h1004] = 32'hBBBB_0002; mem[32'h1008] = 32'hCCCC_0003;
        aw_delay = 0; err_word = -1; w_beats = 0;
        push_expected(32'h1000, 32'h04, 3, 1, 0, -1);
        run_cmd(32'h1000, 32'h04, 11'd3, 1, 0, 0, cyc, wd0);
        n_cmp++;
        if (cyc != 13) begin n_err++; $display("FAIL copy_latency got=%0d want=13", cyc); end
        n_cmp++;
        if (words_done !== 11'd3 || err !== 1'b0) begin
            n_err++; $display("FAIL copy_status got=%0d/%b want=3/0", words_done, err);
        end
        n_cmp++;
        if (w_beats != 3) begin n_err++; $display("FAIL copy_wbeats got=%0d want=3", w_beats); end
        n_cmp++;
        if ({ARID_M, ARLEN_M, ARSIZE_M, ARBURST_M, AWID_M, AWLEN_M, AWSIZE_M, AWBURST_M} !==
            {4'h0, 4'h0, 3'b010, 2'h1, 4'h0, 4'h0, 3'b010, 2'h1}) begin
            n_err++; $display("FAIL axi_attrs got=%h", {ARID_M, ARLEN_M, ARSIZE_M, ARBURST_M,
                                                        AWID_M, AWLEN_M, AWSIZE_M, AWBURST_M});
        end
        check_drained("copy");
    endtask

    task automatic test_aw_stall;
        int cyc; logic [10:0] wd0;
        mem[32'h1100] = 32'h1234_5678;
        aw_delay = 3; w_beats = 0;
        push_expected(32'h1100, 32'h04, 1, 1, 0, -1);
        run_cmd(32'h1100, 32'h04, 11'd1, 1, 0, 0, cyc, wd0);
        n_cmp++;
        if (w_beats != 1) begin n_err++; $display("FAIL stall_wbeats got=%0d want=1", w_beats); end
        n_cmp++;
        if (cyc != 8) begin n_err++; $display("FAIL stall_latency got=%0d want=8", cyc); end
        aw_delay = 0;
        check_drained("stall");
    endtask

    task automatic test_read_error;
        int cyc; logic [10:0] wd0;
        for (int i = 0; i < 4; i++) mem[32'h2000 + 32'(4 * i)] = 32'h5000_0000 + 32'(i);
        err_word = 1; w_beats = 0;
        push_expected(32'h2000, 32'h3000, 4, 1, 1, 1);
        run_cmd(32'h2000, 32'h3000, 11'd4, 1, 1, 0, cyc, wd0);
        n_cmp++;
        if (err !== 1'b1 || words_done !== 11'd1) begin
            n_err++; $display("FAIL rderr_status got=%b/%0d want=1/1", err, words_done);
        end
        n_cmp++;
        if (w_beats != 1 || cyc != 7) begin
            n_err++; $display("FAIL rderr_beats got=%0d/%0d want=1/7", w_beats, cyc);
        end
        err_word = -1;
        check_drained("rderr");
    endtask

    task automatic test_zero_len;
        int cyc; logic [10:0] wd0;
        w_beats = 0;
        run_cmd(32'h1000, 32'h04, 11'd0, 1, 0, 0, cyc, wd0);
        n_cmp++;
        if (cyc != 1 || err !== 1'b0 || words_done !== 11'd0) begin
            n_err++; $display("FAIL zero_len got=%0d/%b/%0d want=1/0/0", cyc, err, words_done);
        end
        n_cmp++;
        if (w_beats != 0 || ar_count != rd_base) begin
            n_err++; $display("FAIL zero_len_axi got=%0d/%0d want=0/0", w_beats, ar_count - rd_base);
        end
        check_drained("zero");
    endtask

    task automatic test_reset_mid;
        int n;
        b_hold = 1;
        push_expected(32'h1000, 32'h04, 1, 1, 0, -1);
        @(negedge ACLK);
        cmd_src = 32'h1000; cmd_dst = 32'h04; cmd_len = 11'd2; cmd_src_inc = 1; cmd_dst_inc = 0;
        cmd_valid = 1;
        @(posedge ACLK);
        #1 cmd_valid = 0;
        n = 0;
        while (!BREADY_M && n < 100) begin @(negedge ACLK); n++; end
        n_cmp++;
        if (BREADY_M !== 1'b1) begin n_err++; $display("FAIL rstmid_reach got=%b want=1", BREADY_M); end
        #2 ARESETn = 0;
        #1;
        n_cmp++;
        if ({ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M, done, busy} !== 7'h00 ||
            WDATA_M !== 32'd0) begin
            n_err++; $display("FAIL rstmid_outputs got=%b wdata=%h want=0/0",
                              {ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M, done, busy}, WDATA_M);
        end
        b_hold = 0;
        @(negedge ACLK);
        ARESETn = 1;
        @(negedge ACLK);
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL rstmid_idle got=%b/%b want=1/0", cmd_ready, busy);
        end
        check_drained("rstmid");
    endtask

    task automatic test_back_to_back;
        int cyc; logic [10:0] wd0;
        mem[32'h08] = 32'h0F0F_00AA;
        push_expected(32'h08, 32'h4000, 2, 0, 1, -1);
        run_cmd(32'h08, 32'h4000, 11'd2, 0, 1, 3, cyc, wd0);
        n_cmp++;
        if (cyc != 9 || words_done !== 11'd2 || err !== 1'b0) begin
            n_err++; $display("FAIL b2b_first got=%0d/%0d/%b want=9/2/0", cyc, words_done, err);
        end
        check_drained("b2b_first");
        push_expected(32'h1000, 32'h5000, 1, 1, 1, -1);
        run_cmd(32'h1000, 32'h5000, 11'd1, 1, 1, 0, cyc, wd0);
        n_cmp++;
        if (wd0 !== 11'd0 || words_done !== 11'd1) begin
            n_err++; $display("FAIL b2b_second got=%0d/%0d want=0/1", wd0, words_done);
        end
        check_drained("b2b_second");
    endtask

    initial begin
        cmd_valid = 0; cmd_src = 0; cmd_dst = 0; cmd_len = 0; cmd_src_inc = 0; cmd_dst_inc = 0;
        test_reset();
        test_copy();
        test_aw_stall();
        test_read_error();
        test_zero_len();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge ACLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
